soc_bus_bridge_mc: RTL and testbench
====================================

// Module: soc_bus_bridge_mc
// PURPOSE
//   Parametrised multi-channel CPU-to-peripheral bus bridge: next generation of the single-cycle SoC bridge.
//   Decodes one CPU access onto N_SLV slave ports (DRAM, timer, LED, switch, 7-seg, ...).
//   Each slave port has its own base/mask window, byte strobes and ack handshake, so multi-cycle slaves are supported.
//   A timeout produces a bus error. Sits between myCPU and all peripherals in miniRV_SoC.
// PARAMETERS
//   N_SLV     6                number of slave channels (1..16)
//   ADDR_W    32               address width
//   DATA_W    32               data width, multiple of 8; BE_W = DATA_W/8
//   SLV_BASE  {N_SLV{32'h0}}   flattened per-slave base addresses, slave i at [i*ADDR_W +: ADDR_W]
//   SLV_MASK  {N_SLV{32'h0}}   flattened per-slave compare masks; hit(i) = (addr & MASK_i) == BASE_i
//   TIMEOUT   15               max cycles waiting for slv_ack before error (>=1, counter width $clog2(TIMEOUT+1))
// PORTS
//   cpu_clk     in   1               single clock; all state on rising edge
//   fpga_rstn   in   1               synchronous active-low reset
//   cpu_req     in   1               access request, sampled in IDLE only
//   cpu_we      in   1               1=write, 0=read
//   cpu_be      in   BE_W            byte strobes (write lanes)
//   cpu_addr    in   ADDR_W          byte address
//   cpu_wdata   in   DATA_W          write data
//   cpu_rdata   out  DATA_W          read data, valid while cpu_ready=1
//   cpu_ready   out  1               one-cycle completion pulse
//   cpu_err     out  1               qualifies cpu_ready: decode miss or timeout
//   slv_sel     out  N_SLV           one-hot channel select
//   slv_we      out  1               write strobe, shared, meaningful with slv_sel
//   slv_be      out  BE_W            latched byte strobes
//   slv_addr    out  ADDR_W          latched address, offset = addr & ~MASK_i
//   slv_wdata   out  DATA_W          latched write data
//   slv_rdata   in   N_SLV*DATA_W    flattened read data, slave i at [i*DATA_W +: DATA_W]
//   slv_ack     in   N_SLV           slave completion; may be asserted in the first sel cycle (zero-wait)
// BEHAVIOUR
//   FSM: IDLE -> ACCESS -> RESP -> IDLE. Decode miss goes IDLE -> RESP directly.
//   IDLE: on cpu_req=1, latch we/be/addr/wdata and decode.
//     Hit: go to ACCESS, store hit index. Overlapping windows: the lowest index wins.
//     Miss: go to RESP with err=1, rdata=0.
//   ACCESS: slv_sel[idx]=1 every cycle; slv_we=latched we; to_cnt increments each cycle.
//     slv_ack[idx]=1: register slv_rdata[idx] (reads; 0 for writes), then go to RESP with err=0.
//     to_cnt==TIMEOUT-1 without ack: go to RESP with err=1, rdata=0.
//     Ack in the same cycle as timeout: ack wins, err=0.
//     Acks on non-selected channels are ignored.
//   RESP: cpu_ready=1 for exactly one cycle, cpu_rdata/cpu_err valid; slv_sel=0; next state IDLE.
//   Latency, cpu_req sampled at cycle 0:
//     zero-wait slave -> ready at cycle 2
//     k-wait slave    -> ready at cycle 2+k
//     miss            -> ready at cycle 1
//   cpu_req is ignored outside IDLE. CPU must drop req on its ready cycle, otherwise the next IDLE cycle starts a new access.
//   slv_we and slv_sel are never asserted outside ACCESS. No write side effect occurs on a miss or in IDLE/RESP.
//   Reset (fpga_rstn=0 at a clock edge), including mid-access:
//     state=IDLE, to_cnt=0, all outputs 0 (cpu_ready, cpu_err, cpu_rdata, slv_sel, slv_we, slv_be, slv_addr, slv_wdata).
//     The pending access is abandoned with no ready pulse.
//   Outputs are driven from registers or from state only; there is no combinational path from cpu_* to slv_*.
// STRUCTURE
//   bridge_pkg: state localparams (S_IDLE=2'd0, S_ACCESS=2'd1, S_RESP=2'd2);
//     default SoC map constants (DRAM 0x0000_0000/0xFFFF_0000,
//     DIG 0xFFFF_F000, TIMER 0xFFFF_F020, LED 0xFFFF_F060, SW 0xFFFF_F070, all masks 0xFFFF_FFFC).
//   Sub-module bridge_addr_decode: combinational priority decoder, (addr, BASE, MASK) -> hit, idx.
//   Top contains the FSM, latches, timeout counter and rdata mux.
// TESTING
//   1 Read at 0xFFFF_F070 (SW, ack same cycle, rdata 0x0000_A5A5) -> ready at cycle 2, rdata=0x0000_A5A5, err=0, sel one-hot on SW only.
//   2 Write 0x1234_5678, be=4'b0011 to DRAM with ack after 3 waits -> sel held 4 cycles, slv_we=1, slv_be=0011, ready at cycle 5.
//   3 Read at unmapped 0x8000_0000 -> ready at cycle 1, err=1, rdata=0, slv_sel never asserted.
//   4 Timer never acks, TIMEOUT=15 -> sel high exactly 15 cycles, ready with err=1. Repeat with ack in cycle 15 -> err=0.
//   5 fpga_rstn=0 during ACCESS cycle 2 -> next edge: all outputs 0, no ready pulse. A subsequent read completes normally.
//   6 Overlapping windows for slaves 1 and 3, both hit -> only slv_sel[1] asserted. Back-to-back requests with req held -> second access starts the cycle after ready.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and default SoC address map for the multi-channel bus bridge.
package bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Default miniRV SoC map
  localparam logic [31:0] DRAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DRAM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] DIG_BASE   = 32'hFFFF_F000;
  localparam logic [31:0] TIMER_BASE = 32'hFFFF_F020;
  localparam logic [31:0] LED_BASE   = 32'hFFFF_F060;
  localparam logic [31:0] SW_BASE    = 32'hFFFF_F070;
  localparam logic [31:0] IO_MASK    = 32'hFFFF_FFFC;

  // Width of a channel index; a single channel still needs one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational priority address decoder: lowest matching channel wins.
module bridge_addr_decode
  import bridge_pkg::*;
#(
  parameter int                      N_SLV    = 6,
  parameter int                      ADDR_W   = 32,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0,
  localparam int                     IW       = idx_w(N_SLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IW-1:0]     idx
);

  logic [N_SLV-1:0] win;

  for (genvar g = 0; g < N_SLV; g++) begin : g_win
    assign win[g] = (addr & SLV_MASK[g*ADDR_W +: ADDR_W]) == SLV_BASE[g*ADDR_W +: ADDR_W];
  end

  // Scan high to low so the lowest hitting index is the one left standing
  always_comb begin
    hit = |win;
    idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (win[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/soc_bus_bridge_mc.sv
// CPU-to-peripheral bridge: decode one access onto N_SLV channels, wait for
// the selected slave's ack (or time out), then return one ready pulse.
module soc_bus_bridge_mc
  import bridge_pkg::*;
#(
  parameter int                      N_SLV    = 6,
  parameter int                      ADDR_W   = 32,
  parameter int                      DATA_W   = 32,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0,
  parameter int                      TIMEOUT  = 15,
  localparam int                     BE_W     = DATA_W / 8
) (
  input  logic                    cpu_clk,
  input  logic                    fpga_rstn,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [BE_W-1:0]         cpu_be,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_err,
  output logic [N_SLV-1:0]        slv_sel,
  output logic                    slv_we,
  output logic [BE_W-1:0]         slv_be,
  output logic [ADDR_W-1:0]       slv_addr,
  output logic [DATA_W-1:0]       slv_wdata,
  input  logic [N_SLV*DATA_W-1:0] slv_rdata,
  input  logic [N_SLV-1:0]        slv_ack
);

  localparam int            IW      = idx_w(N_SLV);
  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t            state;
  logic [IW-1:0]     idx;
  logic              we_q;
  logic [CW-1:0]     to_cnt;

  logic              dec_hit;
  logic [IW-1:0]     dec_idx;
  logic [N_SLV-1:0]  dec_oh;

  logic [ADDR_W-1:0] mask_a  [N_SLV];
  logic [DATA_W-1:0] rdata_a [N_SLV];
  logic              ack_sel;
  logic [DATA_W-1:0] rdata_sel;

  bridge_addr_decode #(
    .N_SLV    (N_SLV),
    .ADDR_W   (ADDR_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .addr (cpu_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  for (genvar g = 0; g < N_SLV; g++) begin : g_unpack
    assign mask_a[g]  = SLV_MASK[g*ADDR_W +: ADDR_W];
    assign rdata_a[g] = slv_rdata[g*DATA_W +: DATA_W];
  end

  assign dec_oh    = N_SLV'(1) << dec_idx;
  assign ack_sel   = slv_ack[idx];
  assign rdata_sel = rdata_a[idx];

  // Bridge FSM; every output is a register so nothing from cpu_* reaches slv_* combinationally
  always_ff @(posedge cpu_clk) begin
    if (!fpga_rstn) begin
      state     <= S_IDLE;
      idx       <= '0;
      we_q      <= 1'b0;
      to_cnt    <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      slv_sel   <= '0;
      slv_we    <= 1'b0;
      slv_be    <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          if (cpu_req) begin
            we_q      <= cpu_we;
            slv_be    <= cpu_be;
            slv_wdata <= cpu_wdata;
            to_cnt    <= '0;
            if (dec_hit) begin
              idx      <= dec_idx;
              slv_sel  <= dec_oh;
              slv_we   <= cpu_we;
              slv_addr <= cpu_addr & ~mask_a[dec_idx];
              state    <= S_ACCESS;
            end else begin
              // Decode miss: answer straight away, never touch a slave
              slv_addr  <= '0;
              cpu_rdata <= '0;
              cpu_err   <= 1'b1;
              cpu_ready <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_ACCESS: begin
          if (ack_sel) begin
            // Ack beats a coincident timeout
            slv_sel   <= '0;
            slv_we    <= 1'b0;
            to_cnt    <= '0;
            cpu_rdata <= we_q ? '0 : rdata_sel;
            cpu_err   <= 1'b0;
            cpu_ready <= 1'b1;
            state     <= S_RESP;
          end else if (to_cnt == TO_LAST) begin
            slv_sel   <= '0;
            slv_we    <= 1'b0;
            to_cnt    <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b1;
            cpu_ready <= 1'b1;
            state     <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_RESP: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          slv_sel   <= '0;
          slv_we    <= 1'b0;
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_bridge_mc.sv
// Randomised bench for soc_bus_bridge_mc against a transaction-level model.
module tb_soc_bus_bridge_mc;
  import bridge_pkg::*;

  localparam int N  = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 15;

  // slot 0 DRAM, 1 TIMER, 2 LED, 3 window overlapping TIMER, 4 SW, 5 DIG
  localparam logic [N*AW-1:0] BASE = {DIG_BASE, SW_BASE, TIMER_BASE, LED_BASE, TIMER_BASE, DRAM_BASE};
  localparam logic [N*AW-1:0] MASK = {IO_MASK, IO_MASK, 32'hFFFF_FFF0, IO_MASK, IO_MASK, DRAM_MASK};

  logic [31:0] base_t [N] = '{DRAM_BASE, TIMER_BASE, LED_BASE, TIMER_BASE, SW_BASE, DIG_BASE};
  logic [31:0] mask_t [N] = '{DRAM_MASK, IO_MASK, IO_MASK, 32'hFFFF_FFF0, IO_MASK, IO_MASK};

  logic          clk = 1'b0;
  logic          rstn;
  logic          cpu_req, cpu_we;
  logic [BW-1:0] cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ready, cpu_err;
  logic [N-1:0]  slv_sel;
  logic          slv_we;
  logic [BW-1:0] slv_be;
  logic [AW-1:0] slv_addr;
  logic [DW-1:0] slv_wdata;
  logic [N*DW-1:0] slv_rdata;
  logic [N-1:0]  slv_ack;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  soc_bus_bridge_mc #(
    .N_SLV(N), .ADDR_W(AW), .DATA_W(DW),
    .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TO)
  ) dut (
    .cpu_clk(clk), .fpga_rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .slv_sel(slv_sel), .slv_we(slv_we), .slv_be(slv_be),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata), .slv_ack(slv_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // First window that matches, -1 on a miss
  function automatic int find(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & mask_t[i]) == base_t[i]) return i;
    return -1;
  endfunction

  task automatic rand_rdata();
    for (int i = 0; i < N; i++) slv_rdata[i*DW +: DW] = $urandom;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(cpu_ready), 32'd0);
    chk({tag, "_err"},   32'(cpu_err),   32'd0);
    chk({tag, "_rdata"}, cpu_rdata,      32'd0);
    chk({tag, "_sel"},   32'(slv_sel),   32'd0);
    chk({tag, "_we"},    32'(slv_we),    32'd0);
    chk({tag, "_be"},    32'(slv_be),    32'd0);
    chk({tag, "_addr"},  slv_addr,       32'd0);
    chk({tag, "_wdata"}, slv_wdata,      32'd0);
  endtask

  // One access; waits >= TO means the slave never answers
  task automatic run(input logic we, input logic [BW-1:0] be, input logic [31:0] addr,
                     input logic [31:0] wd, input int waits);
    int idx, sel_end, rdy;
    logic [N-1:0] oh;
    logic [31:0] cap, exp_rd;
    logic exp_err, in_sel;
    idx = find(addr);
    oh  = '0;
    cap = '0;
    if (idx < 0) begin
      sel_end = 0; rdy = 1; exp_err = 1'b1;
    end else if (waits < TO) begin
      sel_end = 1 + waits; rdy = 2 + waits; exp_err = 1'b0; oh[idx] = 1'b1;
    end else begin
      sel_end = TO; rdy = TO + 1; exp_err = 1'b1; oh[idx] = 1'b1;
    end
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    for (int n = 1; n <= rdy + 1; n++) begin
      @(posedge clk); #1;
      cpu_req = 1'b0;
      cpu_we = $urandom; cpu_addr = $urandom; cpu_wdata = $urandom; cpu_be = BW'($urandom);
      slv_ack = N'($urandom);
      rand_rdata();
      if (idx >= 0) begin
        slv_ack[idx] = (n == 1 + waits) && (waits < TO);
        if (n == 1 + waits) cap = slv_rdata[idx*DW +: DW];
      end
      @(negedge clk);
      in_sel = (idx >= 0) && (n <= sel_end);
      chk("sel",   32'(slv_sel),   32'(in_sel ? oh : '0));
      chk("we",    32'(slv_we),    32'(in_sel & we));
      chk("ready", 32'(cpu_ready), 32'(n == rdy));
      if (in_sel) begin
        chk("saddr",  slv_addr,     addr & ~mask_t[idx]);
        chk("sbe",    32'(slv_be),  32'(be));
        chk("swdata", slv_wdata,    wd);
      end
      if (n == rdy) begin
        exp_rd = (exp_err || we) ? 32'd0 : cap;
        chk("err",   32'(cpu_err), 32'(exp_err));
        chk("rdata", cpu_rdata,    exp_rd);
      end
    end
    slv_ack = '0;
  endtask

  initial begin
    int r, w;
    logic [31:0] a;
    rstn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = '0;
    cpu_addr = '0; cpu_wdata = '0; slv_ack = '0; slv_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    #1 rstn = 1'b1;

    // SW read, zero-wait
    run(1'b0, 4'hF, 32'hFFFF_F070, 32'h0, 0);
    // DRAM write, 3 waits
    run(1'b1, 4'b0011, 32'h0000_0100, 32'h1234_5678, 3);
    // Unmapped read
    run(1'b0, 4'hF, 32'h8000_0000, 32'h0, 0);
    // Timer never acks, then acks in the last allowed cycle
    run(1'b0, 4'hF, 32'hFFFF_F020, 32'h0, TO);
    run(1'b0, 4'hF, 32'hFFFF_F020, 32'h0, TO - 1);
    // Overlap: slot 1 wins at F020, slot 3 alone at F028
    run(1'b1, 4'hC, 32'hFFFF_F020, 32'hCAFE_F00D, 2);
    run(1'b0, 4'hF, 32'hFFFF_F028, 32'h0, 1);

    // Reset in ACCESS cycle 2
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'hFFFF_F023; cpu_wdata = 32'hDEAD_BEEF;
    for (int n = 1; n <= 2; n++) begin
      @(posedge clk); #1;
      cpu_req = 1'b0; slv_ack = '0;
      if (n == 2) rstn = 1'b0;
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("midrst_noready", 32'(cpu_ready), 32'd0);
      chk("midrst_nosel",   32'(slv_sel),   32'd0);
    end
    run(1'b0, 4'hF, 32'hFFFF_F060, 32'h0, 1);

    // Back-to-back with req held: SW acks immediately, 3-cycle period
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 4'hF; cpu_addr = 32'hFFFF_F070; cpu_wdata = '0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      slv_ack = 6'b010000;
      rand_rdata();
      @(negedge clk);
      chk("b2b_ready", 32'(cpu_ready), 32'(n % 3 == 2));
      chk("b2b_sel",   32'(slv_sel),   32'((n % 3 == 1) ? 6'b010000 : 6'b000000));
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    slv_ack = '0;
    repeat (2) @(posedge clk);

    // Random traffic across the map
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: a = {16'h0000, 16'($urandom)};
        3:       a = TIMER_BASE | 32'($urandom_range(0, 3));
        4:       a = LED_BASE   | 32'($urandom_range(0, 3));
        5:       a = SW_BASE    | 32'($urandom_range(0, 3));
        6:       a = DIG_BASE   | 32'($urandom_range(0, 3));
        7:       a = TIMER_BASE | 32'($urandom_range(0, 15));
        default: a = {4'h8, 28'($urandom)};
      endcase
      w = $urandom_range(0, 19);
      if (w >= TO) w = TO;
      run(1'($urandom), BW'($urandom), a, $urandom, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
